// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline.
// Takes the EX/MEM register outputs and runs load/store traffic on a
// request/grant/response data bus. Loads are lane-aligned and then sign- or
// zero-extended. The MEM/WB result is registered, and upstream is stalled
// while a bus transaction is in flight.
//
// Ports
//   sys_clk, sys_rst            clock; synchronous active-high reset
//   in_valid, mempr_mem_*       EX/MEM register contents
//   mem_stall                   hold the EX/MEM register while high
//   dmem_req/we/addr/be/wdata   bus request channel (registered)
//   dmem_gnt/rvalid/rdata/err   bus grant and response
//   mem_wb_*                    registered MEM/WB result; valid is a 1-cycle pulse
//
// state | meaning
// IDLE  | no access in flight; instruction completes in one cycle or is accepted
// REQ   | dmem_req held with stable address/enables/data until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid

module mem_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            in_valid,
    input  logic            mempr_mem_is_write_dmem,
    input  logic [1:0]      mempr_mem_wb_select,
    input  logic [7:0]      mempr_mem_write_width,
    input  logic [XLEN-1:0] mempr_mem_dmem_write_data,
    input  logic [XLEN-1:0] mempr_mem_alu_res,
    input  logic [XLEN-1:0] mempr_mem_pc_plus_4,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_err,
    output logic            mem_wb_valid,
    output logic [1:0]      mem_wb_wb_select,
    output logic [XLEN-1:0] mem_wb_wb_data,
    output logic [1:0]      mem_wb_exc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_BUS   = 2'b10;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      sel_q;
    logic [1:0]      size_q;
    logic            zext_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] pc4_q;
    logic            wb_valid_q;
    logic [1:0]      wb_sel_q;
    logic [XLEN-1:0] wb_data_q;
    logic [1:0]      wb_exc_q;

    logic            unused_width_hi;
    assign unused_width_hi = ^mempr_mem_write_width[7:5];

    // Non-load write-back value; a store tagged as "load" write-back gets 0.
    function automatic logic [XLEN-1:0] nonload_val(input logic [1:0] sel,
                                                    input logic [XLEN-1:0] alu,
                                                    input logic [XLEN-1:0] pc4);
        case (sel)
            2'b00:   return alu;
            2'b10:   return pc4;
            default: return '0;
        endcase
    endfunction

    logic       mem_acc;
    logic [1:0] size_in;
    logic       misalign;
    logic       timeout_hit;
    logic       store_done;
    logic       load_done;
    logic       in_flight;

    assign mem_acc = in_valid & (mempr_mem_is_write_dmem | (mempr_mem_wb_select == 2'b01));

    always_comb begin
        size_in = SZ_WORD;
        case (mempr_mem_write_width[3:0])
            4'b0001: size_in = SZ_BYTE;
            4'b0011: size_in = SZ_HALF;
            default: size_in = SZ_WORD;
        endcase
    end

    assign misalign = ((size_in == SZ_HALF) & mempr_mem_alu_res[0]) |
                      ((size_in == SZ_WORD) & (mempr_mem_alu_res[1:0] != 2'b00));

    assign in_flight   = (state_q == S_REQ) | (state_q == S_WAIT);
    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign store_done  = (state_q == S_REQ) & dmem_gnt & we_q;
    assign load_done   = (state_q == S_WAIT) & dmem_rvalid;

    // Stall drops in the completion (or timeout) cycle so the upstream
    // register advances on the same edge the result is registered.
    assign mem_stall = ~sys_rst &
                       (((state_q == S_IDLE) & mem_acc & ~misalign) |
                        (in_flight & ~(store_done | load_done) & ~timeout_hit));

    // Load lane extraction at the latched byte offset.
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] load_val;
    assign rshift = dmem_rdata >> {addr_lo_q, 3'b000};

    always_comb begin
        load_val = dmem_rdata;
        case (size_q)
            SZ_BYTE: load_val = zext_q ? {{(XLEN-8){1'b0}}, rshift[7:0]}
                                       : {{(XLEN-8){rshift[7]}}, rshift[7:0]};
            SZ_HALF: load_val = zext_q ? {{(XLEN-16){1'b0}}, rshift[15:0]}
                                       : {{(XLEN-16){rshift[15]}}, rshift[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in;

    always_comb begin
        be_in    = 4'hF;
        wdata_in = mempr_mem_dmem_write_data;
        case (size_in)
            SZ_BYTE: begin
                be_in    = 4'b0001 << mempr_mem_alu_res[1:0];
                wdata_in = {4{mempr_mem_dmem_write_data[7:0]}};
            end
            SZ_HALF: begin
                be_in    = 4'b0011 << mempr_mem_alu_res[1:0];
                wdata_in = {2{mempr_mem_dmem_write_data[15:0]}};
            end
            default: begin
                be_in    = 4'hF;
                wdata_in = mempr_mem_dmem_write_data;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            size_q     <= SZ_BYTE;
            zext_q     <= 1'b0;
            addr_lo_q  <= '0;
            pc4_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_sel_q   <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= EXC_NONE;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (mem_acc && !misalign) begin
                            state_q   <= S_REQ;
                            cnt_q     <= '0;
                            we_q      <= mempr_mem_is_write_dmem;
                            addr_q    <= {mempr_mem_alu_res[XLEN-1:2], 2'b00};
                            be_q      <= be_in;
                            wdata_q   <= wdata_in;
                            sel_q     <= mempr_mem_wb_select;
                            size_q    <= size_in;
                            zext_q    <= mempr_mem_write_width[4];
                            addr_lo_q <= mempr_mem_alu_res[1:0];
                            pc4_q     <= mempr_mem_pc_plus_4;
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_sel_q   <= mempr_mem_wb_select;
                            wb_exc_q   <= mem_acc ? EXC_ALIGN : EXC_NONE;
                            wb_data_q  <= mem_acc ? '0
                                        : nonload_val(mempr_mem_wb_select,
                                                      mempr_mem_alu_res,
                                                      mempr_mem_pc_plus_4);
                        end
                    end
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (dmem_gnt && we_q) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_sel_q   <= sel_q;
                        wb_exc_q   <= dmem_err ? EXC_BUS : EXC_NONE;
                        wb_data_q  <= dmem_err ? '0
                                    : nonload_val(sel_q, {addr_q[XLEN-1:2], addr_lo_q}, pc4_q);
                    end else if (timeout_hit) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_sel_q   <= sel_q;
                        wb_exc_q   <= EXC_BUS;
                        wb_data_q  <= '0;
                    end else if (dmem_gnt) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (dmem_rvalid || timeout_hit) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_sel_q   <= sel_q;
                        if (dmem_rvalid && !dmem_err) begin
                            wb_exc_q  <= EXC_NONE;
                            wb_data_q <= load_val;
                        end else begin
                            wb_exc_q  <= EXC_BUS;
                            wb_data_q <= '0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem_req         = (state_q == S_REQ);
    assign dmem_we          = we_q;
    assign dmem_addr        = addr_q;
    assign dmem_be          = be_q;
    assign dmem_wdata       = wdata_q;
    assign mem_wb_valid     = wb_valid_q;
    assign mem_wb_wb_select = wb_sel_q;
    assign mem_wb_wb_data   = wb_data_q;
    assign mem_wb_exc       = wb_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Inputs are driven 1 time unit
// after the rising edge, outputs are checked 1 time unit later.

module tb_mem_stage;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic        is_write;
    logic [1:0]  wb_select;
    logic [7:0]  width;
    logic [31:0] st_data;
    logic [31:0] alu_res;
    logic [31:0] pc_plus_4;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic        mem_wb_valid;
    logic [1:0]  mem_wb_wb_select;
    logic [31:0] mem_wb_wb_data;
    logic [1:0]  mem_wb_exc;

    int vectors     = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(64)) dut (
        .sys_clk                   (sys_clk),
        .sys_rst                   (sys_rst),
        .in_valid                  (in_valid),
        .mempr_mem_is_write_dmem   (is_write),
        .mempr_mem_wb_select       (wb_select),
        .mempr_mem_write_width     (width),
        .mempr_mem_dmem_write_data (st_data),
        .mempr_mem_alu_res         (alu_res),
        .mempr_mem_pc_plus_4       (pc_plus_4),
        .mem_stall                 (mem_stall),
        .dmem_req                  (dmem_req),
        .dmem_we                   (dmem_we),
        .dmem_addr                 (dmem_addr),
        .dmem_be                   (dmem_be),
        .dmem_wdata                (dmem_wdata),
        .dmem_gnt                  (dmem_gnt),
        .dmem_rvalid               (dmem_rvalid),
        .dmem_rdata                (dmem_rdata),
        .dmem_err                  (dmem_err),
        .mem_wb_valid              (mem_wb_valid),
        .mem_wb_wb_select          (mem_wb_wb_select),
        .mem_wb_wb_data            (mem_wb_wb_data),
        .mem_wb_exc                (mem_wb_exc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input logic v, input logic we, input logic [1:0] sel,
                             input logic [7:0] w, input logic [31:0] d,
                             input logic [31:0] a, input logic [31:0] pc4);
        in_valid  = v;
        is_write  = we;
        wb_select = sel;
        width     = w;
        st_data   = d;
        alu_res   = a;
        pc_plus_4 = pc4;
    endtask

    // Load granted on the first REQ cycle, rvalid two cycles after the grant.
    task automatic run_load(input string tag, input logic [31:0] a, input logic [7:0] w,
                            input logic [31:0] rd, input logic [31:0] exp);
        set_instr(1'b1, 1'b0, 2'b01, w, 32'h0, a, 32'h0);
        settle();
        check({tag, "_accept_stall"}, {31'b0, mem_stall}, 32'd1);
        tick();
        dmem_gnt = 1'b1;
        settle();
        check({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        tick();
        dmem_gnt = 1'b0;
        settle();
        check({tag, "_wait_stall"}, {31'b0, mem_stall}, 32'd1);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd;
        settle();
        check({tag, "_done_stall"}, {31'b0, mem_stall}, 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        in_valid    = 1'b0;
        settle();
        check({tag, "_valid"}, {31'b0, mem_wb_valid}, 32'd1);
        check({tag, "_data"}, mem_wb_wb_data, exp);
        check({tag, "_exc"}, {30'b0, mem_wb_exc}, 32'd0);
    endtask

    int n;

    initial begin
        sys_rst     = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        dmem_err    = 1'b0;
        set_instr(1'b0, 1'b0, 2'b00, 8'h0F, 32'h0, 32'h0, 32'h0);

        // Reset state
        tick();
        tick();
        check("rst_stall", {31'b0, mem_stall}, 32'd0);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_valid", {31'b0, mem_wb_valid}, 32'd0);
        check("rst_wbdata", mem_wb_wb_data, 32'h0);
        sys_rst = 1'b0;

        // ALU op: one-cycle latency, no stall
        set_instr(1'b1, 1'b0, 2'b00, 8'h0F, 32'h0, 32'h0000_1234, 32'h0000_0008);
        settle();
        check("alu_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        in_valid = 1'b0;
        settle();
        check("alu_valid", {31'b0, mem_wb_valid}, 32'd1);
        check("alu_data", mem_wb_wb_data, 32'h0000_1234);
        check("alu_exc", {30'b0, mem_wb_exc}, 32'd0);
        tick();
        check("alu_valid_pulse", {31'b0, mem_wb_valid}, 32'd0);

        // pc+4 write-back
        set_instr(1'b1, 1'b0, 2'b10, 8'h0F, 32'h0, 32'h0000_1111, 32'h0000_2004);
        tick();
        in_valid = 1'b0;
        settle();
        check("pc4_data", mem_wb_wb_data, 32'h0000_2004);

        // Byte store at 0x103, grant in the third REQ cycle
        set_instr(1'b1, 1'b1, 2'b11, 8'h01, 32'h0000_00AB, 32'h0000_0103, 32'h0);
        settle();
        check("sb_stall_accept", {31'b0, mem_stall}, 32'd1);
        tick();
        check("sb_req", {31'b0, dmem_req}, 32'd1);
        check("sb_we", {31'b0, dmem_we}, 32'd1);
        check("sb_addr", dmem_addr, 32'h0000_0100);
        check("sb_be", {28'b0, dmem_be}, 32'h8);
        check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
        check("sb_stall_r1", {31'b0, mem_stall}, 32'd1);
        tick();
        check("sb_stall_r2", {31'b0, mem_stall}, 32'd1);
        check("sb_addr_hold", dmem_addr, 32'h0000_0100);
        tick();
        dmem_gnt = 1'b1;
        settle();
        check("sb_stall_gnt", {31'b0, mem_stall}, 32'd0);
        check("sb_no_early_valid", {31'b0, mem_wb_valid}, 32'd0);
        tick();
        dmem_gnt = 1'b0;
        in_valid = 1'b0;
        settle();
        check("sb_valid", {31'b0, mem_wb_valid}, 32'd1);
        check("sb_exc", {30'b0, mem_wb_exc}, 32'd0);
        check("sb_req_drop", {31'b0, dmem_req}, 32'd0);
        tick();
        check("sb_single_pulse", {31'b0, mem_wb_valid}, 32'd0);

        // Half store at 0x102 completing with a bus error
        set_instr(1'b1, 1'b1, 2'b11, 8'h03, 32'h1234_CDEF, 32'h0000_0102, 32'h0);
        tick();
        check("sh_be", {28'b0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hCDEF_CDEF);
        dmem_gnt = 1'b1;
        dmem_err = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        dmem_err = 1'b0;
        in_valid = 1'b0;
        settle();
        check("sh_err_valid", {31'b0, mem_wb_valid}, 32'd1);
        check("sh_err_exc", {30'b0, mem_wb_exc}, 32'd2);

        // Loads with alignment and extension
        run_load("lh_s", 32'h0000_0202, 8'h03, 32'h8001_FFFF, 32'hFFFF_8001);
        run_load("lh_z", 32'h0000_0202, 8'h13, 32'h8001_FFFF, 32'h0000_8001);
        run_load("lb_s", 32'h0000_0301, 8'h01, 32'h1234_8056, 32'hFFFF_FF80);
        run_load("lw",   32'h0000_0400, 8'h0F, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Misaligned word load: no bus activity, exc=01
        set_instr(1'b1, 1'b0, 2'b01, 8'h0F, 32'h0, 32'h0000_0301, 32'h0);
        settle();
        check("mis_stall", {31'b0, mem_stall}, 32'd0);
        tick();
        in_valid = 1'b0;
        settle();
        check("mis_valid", {31'b0, mem_wb_valid}, 32'd1);
        check("mis_exc", {30'b0, mem_wb_exc}, 32'd1);
        check("mis_data", mem_wb_wb_data, 32'h0);
        check("mis_req", {31'b0, dmem_req}, 32'd0);

        // Load never granted: stall for TIMEOUT_CYCLES-1 REQ cycles, then abort
        set_instr(1'b1, 1'b0, 2'b01, 8'h0F, 32'h0, 32'h0000_0400, 32'h0000_0404);
        tick();
        n = 0;
        while (mem_stall === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("to_stall_cycles", n, 32'd63);
        check("to_req_last", {31'b0, dmem_req}, 32'd1);
        tick();
        // Next instruction accepted; a stray grant in IDLE is ignored
        set_instr(1'b1, 1'b0, 2'b00, 8'h0F, 32'h0, 32'h0000_0055, 32'h0);
        dmem_gnt = 1'b1;
        settle();
        check("to_valid", {31'b0, mem_wb_valid}, 32'd1);
        check("to_exc", {30'b0, mem_wb_exc}, 32'd2);
        check("to_data", mem_wb_wb_data, 32'h0);
        check("to_req_idle", {31'b0, dmem_req}, 32'd0);
        tick();
        dmem_gnt = 1'b0;
        in_valid = 1'b0;
        settle();
        check("after_to_valid", {31'b0, mem_wb_valid}, 32'd1);
        check("after_to_data", mem_wb_wb_data, 32'h0000_0055);
        check("after_to_exc", {30'b0, mem_wb_exc}, 32'd0);

        // Reset in WAIT, then a late rvalid
        set_instr(1'b1, 1'b0, 2'b01, 8'h0F, 32'h0, 32'h0000_0500, 32'h0);
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        settle();
        check("rw_wait_stall", {31'b0, mem_stall}, 32'd1);
        sys_rst = 1'b1;
        settle();
        check("rw_stall_in_rst", {31'b0, mem_stall}, 32'd0);
        tick();
        sys_rst     = 1'b0;
        in_valid    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        settle();
        check("rw_req", {31'b0, dmem_req}, 32'd0);
        check("rw_addr", dmem_addr, 32'h0);
        check("rw_be", {28'b0, dmem_be}, 32'h0);
        check("rw_valid", {31'b0, mem_wb_valid}, 32'd0);
        check("rw_wbdata", mem_wb_wb_data, 32'h0);
        check("rw_exc", {30'b0, mem_wb_exc}, 32'd0);
        tick();
        dmem_rvalid = 1'b0;
        settle();
        check("rw_no_result", {31'b0, mem_wb_valid}, 32'd0);
        check("rw_stall_after", {31'b0, mem_stall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage pipeline.
- Consumes the EX/MEM pipeline register outputs and performs load/store traffic on a request/grant/response data-memory bus. Loads get byte-lane alignment and sign or zero extension.
- Drives a registered MEM/WB result toward write-back.
- Raises a stall to upstream stages while a bus transaction is in flight.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 64, number of cycles in REQ+WAIT after which the access is aborted as a bus error.

Ports:
- sys_clk  in  1  clock; all state updates on posedge.
- sys_rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  EX/MEM register holds a valid instruction.
- mempr_mem_is_write_dmem  in  1  1 = store.
- mempr_mem_wb_select  in  2  00 ALU, 01 dmem load, 10 pc+4, 11 no write-back.
- mempr_mem_write_width  in  8  [3:0] size mask: 0001 byte, 0011 half, 1111 word (other patterns = word); [4] = load zero-extend; [7:5] ignored.
- mempr_mem_dmem_write_data  in  XLEN  store data, right-aligned.
- mempr_mem_alu_res  in  XLEN  ALU result; this is the address for loads/stores.
- mempr_mem_pc_plus_4  in  XLEN  link value.
- mem_stall  out  1  upstream must hold the EX/MEM register while 1.
- dmem_req  out  1  bus request.
- dmem_we  out  1  request is a write.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read word.
- dmem_err  in  1  error, qualified with gnt (store) or rvalid (load).
- mem_wb_valid  out  1  one-cycle pulse per retired instruction.
- mem_wb_wb_select  out  2  copy of wb_select.
- mem_wb_wb_data  out  XLEN  selected write-back value.
- mem_wb_exc  out  2  00 none, 01 misaligned, 10 bus error/timeout.

Behaviour:
- Memory access = in_valid & (is_write_dmem | wb_select==01). Store takes priority if both are set.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory instruction or misaligned access:
  - No stall.
  - Next edge: mem_wb_valid=1 and outputs loaded; 1-cycle latency.
  - Misaligned: mem_wb_exc=01, wb_data=0, no bus activity.
- IDLE, aligned access (accept cycle):
  - mem_stall=1.
  - Latch wb_select, size, zero-extend flag, addr[1:0], and pc+4.
  - Register dmem_addr, dmem_be = mask<<addr[1:0], dmem_wdata (byte replicated x4, half x2), dmem_we.
  - Go to REQ.
- REQ:
  - dmem_req=1; address, enables, data and we are held stable until dmem_gnt.
  - On gnt with we=1: store completes; mem_stall=0 this cycle; next edge go to IDLE with mem_wb_valid=1, exc=10 if dmem_err else 00.
  - On gnt with we=0: go to WAIT. dmem_req drops the cycle after gnt.
- WAIT:
  - mem_stall=1 until dmem_rvalid. rvalid is earliest the cycle after gnt.
  - On rvalid: mem_stall=0; extract byte/half at latched addr[1:0]; sign-extend unless the zero-extend flag is set.
  - Next edge go to IDLE with mem_wb_valid=1, wb_data=extracted value (exc=10 and wb_data=0 if dmem_err).
- mem_wb_wb_data for non-load: 00 → alu_res, 10 → pc+4, 11 → 0.
- Stall timing: mem_stall=0 exactly in the completion cycle, so the upstream register advances on the same edge the result is registered. No instruction is accepted twice.
- Timeout:
  - A counter is cleared on accept and increments each cycle in REQ/WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: mem_stall=0, next edge go to IDLE with mem_wb_valid=1 and exc=10.
  - A later gnt/rvalid is ignored.
- dmem_gnt/dmem_rvalid arriving in IDLE are ignored.
- mem_wb_valid is 0 on any cycle without a completion. Other mem_wb_* outputs hold their last value.
- Reset (any state, including mid-transaction):
  - Next edge: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, mem_wb_valid=0, mem_wb_wb_select=0, mem_wb_wb_data=0, mem_wb_exc=0.
  - mem_stall=0 while sys_rst=1.
  - No result is produced for an aborted access.

Test Plan:
- ALU op (wb_select=00, alu_res=0x1234) with in_valid → no stall; next cycle mem_wb_valid=1, wb_data=0x1234, exc=00.
- Byte store data=0x000000AB at addr 0x103, gnt 2 cycles after req → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_addr=0x100; stall lasts 3 cycles; one mem_wb_valid pulse.
- Signed half load at 0x202, rdata=0x8001FFFF → wb_data=0xFFFF8001. Same access with the zero-extend bit set → 0x00008001.
- Word load at 0x301 → exc=01, no dmem_req, valid next cycle. Load with gnt never asserted → exc=10 after TIMEOUT_CYCLES, then the next instruction is accepted.
- Assert sys_rst while in WAIT, then pulse rvalid after reset → no mem_wb_valid; all outputs 0; dmem_req=0.
